// File: rtl/control_sequencer.sv
// control_sequencer
//
// Hardwired control unit for the bus-based CPU datapath. A single FSM walks
// every instruction through fetch (T0..T2, with T1W absorbing memory wait
// cycles) and a class-dependent execute tail (T3..T6), then either fetches
// again, idles, or parks in HALT.
//
// Ports
//   clock      : system clock, all state advances on its rising edge
//   clear      : asynchronous active-high reset (forces IDLE, all outputs 0)
//   run        : permits fetch of a new instruction (sampled in IDLE and at
//                the last step of an instruction only)
//   mem_ready  : memory read data valid on Mdatain this cycle
//   ir         : instruction register [31:27] opcode, [26:23] Ra,
//                [22:19] Rb, [18:15] Rc
//   reg_in     : one-hot R0..R15 load enables
//   reg_out    : one-hot R0..R15 bus drives
//   PCout, Zhighout, Zlowout, MDRout, HIout, LOout : bus drive selects
//   PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC, Read : strobes
//   alu_op     : ALU opcode, 0 whenever the ALU result is not captured
//   halted     : high in HALT
//   state_dbg  : current FSM state, for observation only
//
// Memory read handshake: Read is the request and stays high from T1 until
// the cycle in which mem_ready is seen; that cycle is the transfer, so MDRin
// equals mem_ready while Read is high and the FSM moves on at the following
// edge. mem_ready outside T1/T1W has no effect.

module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [4:0]  alu_op,
  output logic        halted,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T1W  = 4'd3,
    T2   = 4'd4,
    T3   = 4'd5,
    T4   = 4'd6,
    T5   = 4'd7,
    T6   = 4'd8,
    HALT = 4'd9
  } state_t;

  state_t state, next_state, end_state;

  logic [4:0]  opcode;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic        is_rtype, is_muldiv, is_unary, is_nop;
  logic        unused_ir;

  assign opcode    = ir[31:27];
  assign ra_oh     = 16'h0001 << ir[26:23];
  assign rb_oh     = 16'h0001 << ir[22:19];
  assign rc_oh     = 16'h0001 << ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_rtype  = (opcode >= 5'b00011) && (opcode <= 5'b01110);
  assign is_muldiv = (opcode == 5'b10000) || (opcode == 5'b01111);
  assign is_unary  = (opcode == 5'b10001) || (opcode == 5'b10010);
  assign is_nop    = (opcode == 5'b11010);

  assign state_dbg = state;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    // Where the FSM goes after the final step of any instruction.
    end_state  = run ? T0 : IDLE;
    reg_in     = '0;
    reg_out    = '0;
    PCout      = 1'b0;
    Zhighout   = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    PCin       = 1'b0;
    IRin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    alu_op     = '0;
    halted     = 1'b0;

    case (state)
      IDLE: begin
        if (run) next_state = T0;
      end
      T0: begin
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin        = 1'b1;
        next_state = T1;
      end
      T1: begin
        Zlowout    = 1'b1;
        PCin       = 1'b1;
        Read       = 1'b1;
        MDRin      = mem_ready;
        next_state = mem_ready ? T2 : T1W;
      end
      T1W: begin
        Read  = 1'b1;
        MDRin = mem_ready;
        if (mem_ready) next_state = T2;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        // The class decision here uses ir as presented during T2.
        if (is_rtype || is_muldiv || is_unary) next_state = T3;
        else if (is_nop)                       next_state = end_state;
        else                                   next_state = HALT;
      end
      T3: begin
        reg_out = rb_oh;
        if (is_unary) begin
          alu_op = opcode;
          Zin    = 1'b1;
        end else begin
          Yin = 1'b1;
        end
        next_state = T4;
      end
      T4: begin
        if (is_unary) begin
          Zlowout    = 1'b1;
          reg_in     = ra_oh;
          next_state = end_state;
        end else begin
          reg_out    = rc_oh;
          alu_op     = opcode;
          Zin        = 1'b1;
          next_state = T5;
        end
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin       = 1'b1;
          next_state = T6;
        end else begin
          reg_in     = ra_oh;
          next_state = end_state;
        end
      end
      T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        next_state = end_state;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//
// Drives instructions through control_sequencer and compares the full bundle
// of control outputs every cycle against an expected sequence built from the
// per-class step tables (fetch, then execute steps by opcode class).

module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, read;
    logic [4:0] alu_op;
    logic halted;
  } ctl_t;

  // clock / reset block
  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  logic        run, mem_ready;
  logic [31:0] ir;
  logic [15:0] reg_in, reg_out;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC, Read;
  logic [4:0] alu_op;
  logic       halted;
  logic [3:0] state_dbg;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .reg_in(reg_in), .reg_out(reg_out),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .alu_op(alu_op), .halted(halted), .state_dbg(state_dbg)
  );

  ctl_t obs;
  assign obs = {reg_in, reg_out, PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
                PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC, Read,
                alu_op, halted};

  // scoreboard: expected control bundles, mem_ready to drive (2 = random),
  // and a step name per cycle
  ctl_t  exp_q[$];
  int    mr_q[$];
  string tag_q[$];

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    logic [15:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // 0 R-type, 1 mul/div, 2 neg/not, 3 nop, 4 halt/illegal
  function automatic int op_class(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd14) return 0;
    if (op == 5'd15 || op == 5'd16) return 1;
    if (op == 5'd17 || op == 5'd18) return 2;
    if (op == 5'd26) return 3;
    return 4;
  endfunction

  function automatic void push(input ctl_t v, input int mr, input string t);
    exp_q.push_back(v);
    mr_q.push_back(mr);
    tag_q.push_back(t);
  endfunction

  // reference model: expected per-cycle outputs for one instruction
  function automatic void build_instr(input logic [31:0] instr, input int waits);
    ctl_t v;
    logic [4:0] op;
    int cls;
    op  = instr[31:27];
    cls = op_class(op);
    v = '0; v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.z_in = 1;
    push(v, 2, "T0");
    v = '0; v.zlow_out = 1; v.pc_in = 1; v.read = 1; v.mdr_in = (waits == 0);
    push(v, (waits == 0) ? 1 : 0, "T1");
    for (int w = 1; w <= waits; w++) begin
      v = '0; v.read = 1; v.mdr_in = (w == waits);
      push(v, (w == waits) ? 1 : 0, "T1W");
    end
    v = '0; v.mdr_out = 1; v.ir_in = 1;
    push(v, 2, "T2");
    if (cls == 0 || cls == 1) begin
      v = '0; v.reg_out = onehot(instr[22:19]); v.y_in = 1;
      push(v, 2, "T3");
      v = '0; v.reg_out = onehot(instr[18:15]); v.alu_op = op; v.z_in = 1;
      push(v, 2, "T4");
      v = '0; v.zlow_out = 1;
      if (cls == 0) v.reg_in = onehot(instr[26:23]);
      else          v.lo_in = 1;
      push(v, 2, "T5");
      if (cls == 1) begin
        v = '0; v.zhigh_out = 1; v.hi_in = 1;
        push(v, 2, "T6");
      end
    end else if (cls == 2) begin
      v = '0; v.reg_out = onehot(instr[22:19]); v.alu_op = op; v.z_in = 1;
      push(v, 2, "T3");
      v = '0; v.zlow_out = 1; v.reg_in = onehot(instr[26:23]);
      push(v, 2, "T4");
    end
  endfunction

  task automatic check(input ctl_t e, input string tag);
    cmp_cnt++;
    assert (obs === e) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // driver: one cycle, called at posedge+1, returns at next posedge+1
  task automatic step(input ctl_t e, input int mr, input bit rn, input string tag);
    run       = rn;
    mem_ready = (mr == 2) ? 1'($urandom_range(0, 1)) : 1'(mr);
    #1;
    check(e, tag);
    @(posedge clock);
    #1;
  endtask

  // runs one instruction starting in its T0 cycle; abort_at >= 0 pulses
  // clear at that step index instead of completing it
  task automatic run_instr(input logic [31:0] instr, input int waits,
                           input bit run_end, input int abort_at);
    ctl_t  e;
    int    mr, n;
    string t;
    ir = instr;
    build_instr(instr, waits);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e  = exp_q.pop_front();
      mr = mr_q.pop_front();
      t  = tag_q.pop_front();
      if (i == abort_at) begin
        clear = 1'b1;
        run   = 1'b1;
        #1;
        check('0, $sformatf("ir=%h clear_async", instr));
        @(posedge clock);
        #1;
        clear = 1'b0;
        exp_q.delete();
        mr_q.delete();
        tag_q.delete();
        return;
      end
      step(e, mr, (i == n - 1) ? run_end : 1'($urandom_range(0, 1)),
           $sformatf("ir=%h %s", instr, t));
    end
  endtask

  // after a run_end=0 instruction: some idle cycles, then restart
  task automatic idle_then_restart(input int k);
    for (int i = 0; i < k; i++) step('0, 2, 1'b0, "idle_hold");
    step('0, 2, 1'b1, "idle_restart");
  endtask

  task automatic halt_check(input logic [31:0] instr);
    ctl_t hv;
    hv = '0;
    hv.halted = 1'b1;
    run_instr(instr, $urandom_range(0, 2), 1'b1, -1);
    for (int i = 0; i < 5; i++)
      step(hv, 2, 1'($urandom_range(0, 1)), $sformatf("ir=%h halt", instr));
    clear = 1'b1;
    #1;
    check('0, "halt_clear_async");
    @(posedge clock);
    #1;
    clear = 1'b0;
    step('0, 2, 1'b1, "idle_after_halt");
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    int pick;
    bit rend;

    run       = 1'b1;
    mem_ready = 1'b0;
    ir        = '0;
    clear     = 1'b1;

    // reset: clear wins over run
    repeat (2) @(posedge clock);
    #1;
    check('0, "reset");
    @(posedge clock);
    #1;
    check('0, "reset_hold");
    clear = 1'b0;
    step('0, 2, 1'b1, "idle_start");

    // directed instructions
    run_instr(32'h2A2B8000, 0, 1'b1, -1);
    run_instr(32'h80130000, 0, 1'b1, -1);
    run_instr(enc(5'b00011, 4'd4, 4'd3, 4'd7), 3, 1'b1, -1);
    run_instr(enc(5'b01111, 4'd9, 4'd15, 4'd0), 1, 1'b1, -1);
    run_instr(enc(5'b10001, 4'd15, 4'd1, 4'd2), 0, 1'b1, -1);
    run_instr(enc(5'b10010, 4'd0, 4'd14, 4'd5), 2, 1'b1, -1);
    run_instr(enc(5'b11010, 4'd3, 4'd3, 4'd3), 0, 1'b1, -1);
    run_instr(enc(5'b01110, 4'd8, 4'd12, 4'd11), 0, 1'b1, -1);

    // run dropped mid-instruction: instruction completes, then IDLE
    run_instr(32'h2A2B8000, 0, 1'b0, -1);
    idle_then_restart(2);

    // clear during T4 of an add
    run_instr(32'h2A2B8000, 0, 1'b1, 4);
    step('0, 2, 1'b1, "idle_after_clear");
    run_instr(32'h2A2B8000, 1, 1'b1, -1);

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0:       op = 5'($urandom_range(3, 14));
        1:       op = ($urandom_range(0, 1) != 0) ? 5'd15 : 5'd16;
        2:       op = ($urandom_range(0, 1) != 0) ? 5'd17 : 5'd18;
        default: op = 5'd26;
      endcase
      rend = 1'($urandom_range(0, 1));
      run_instr(enc(op, 4'($urandom), 4'($urandom), 4'($urandom)),
                $urandom_range(0, 3), rend, -1);
      if (!rend) idle_then_restart($urandom_range(0, 2));
    end

    // halt and illegal opcode
    halt_check(32'hD8000000);
    halt_check(32'hF8000000);
    run_instr(enc(5'b00100, 4'd1, 4'd2, 4'd3), 0, 1'b0, -1);
    step('0, 2, 1'b0, "final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
